// File: rtl/inv_rounds.sv
// inv_rounds: iterative AES-128 inverse cipher rounds, one round per clock; AES_DEC_BUSY_EN adds a busy output
module inv_rounds #(
  parameter int NR = 10
) (
`ifdef AES_DEC_BUSY_EN
  output logic         busy,
`endif
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] cipher_text,
  input  logic [0:127] round_key,
  output logic [0:127] dec_data,
  output logic [3:0]   round_num,
  output logic         valid_flag
);
  localparam logic [3:0] LAST = 4'(NR);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [0:127] st_q, st_d, dec_q, dec_d, sb, ak, mc;
  logic [3:0] rn_q, rn_d;
  logic vf_q, vf_d;
  function automatic logic [7:0] isb(input logic [7:0] b);
    case (b)
      8'h00: isb = 8'h52; 8'h01: isb = 8'h09; 8'h02: isb = 8'h6a; 8'h03: isb = 8'hd5; 8'h04: isb = 8'h30; 8'h05: isb = 8'h36; 8'h06: isb = 8'ha5; 8'h07: isb = 8'h38;
      8'h08: isb = 8'hbf; 8'h09: isb = 8'h40; 8'h0a: isb = 8'ha3; 8'h0b: isb = 8'h9e; 8'h0c: isb = 8'h81; 8'h0d: isb = 8'hf3; 8'h0e: isb = 8'hd7; 8'h0f: isb = 8'hfb;
      8'h10: isb = 8'h7c; 8'h11: isb = 8'he3; 8'h12: isb = 8'h39; 8'h13: isb = 8'h82; 8'h14: isb = 8'h9b; 8'h15: isb = 8'h2f; 8'h16: isb = 8'hff; 8'h17: isb = 8'h87;
      8'h18: isb = 8'h34; 8'h19: isb = 8'h8e; 8'h1a: isb = 8'h43; 8'h1b: isb = 8'h44; 8'h1c: isb = 8'hc4; 8'h1d: isb = 8'hde; 8'h1e: isb = 8'he9; 8'h1f: isb = 8'hcb;
      8'h20: isb = 8'h54; 8'h21: isb = 8'h7b; 8'h22: isb = 8'h94; 8'h23: isb = 8'h32; 8'h24: isb = 8'ha6; 8'h25: isb = 8'hc2; 8'h26: isb = 8'h23; 8'h27: isb = 8'h3d;
      8'h28: isb = 8'hee; 8'h29: isb = 8'h4c; 8'h2a: isb = 8'h95; 8'h2b: isb = 8'h0b; 8'h2c: isb = 8'h42; 8'h2d: isb = 8'hfa; 8'h2e: isb = 8'hc3; 8'h2f: isb = 8'h4e;
      8'h30: isb = 8'h08; 8'h31: isb = 8'h2e; 8'h32: isb = 8'ha1; 8'h33: isb = 8'h66; 8'h34: isb = 8'h28; 8'h35: isb = 8'hd9; 8'h36: isb = 8'h24; 8'h37: isb = 8'hb2;
      8'h38: isb = 8'h76; 8'h39: isb = 8'h5b; 8'h3a: isb = 8'ha2; 8'h3b: isb = 8'h49; 8'h3c: isb = 8'h6d; 8'h3d: isb = 8'h8b; 8'h3e: isb = 8'hd1; 8'h3f: isb = 8'h25;
      8'h40: isb = 8'h72; 8'h41: isb = 8'hf8; 8'h42: isb = 8'hf6; 8'h43: isb = 8'h64; 8'h44: isb = 8'h86; 8'h45: isb = 8'h68; 8'h46: isb = 8'h98; 8'h47: isb = 8'h16;
      8'h48: isb = 8'hd4; 8'h49: isb = 8'ha4; 8'h4a: isb = 8'h5c; 8'h4b: isb = 8'hcc; 8'h4c: isb = 8'h5d; 8'h4d: isb = 8'h65; 8'h4e: isb = 8'hb6; 8'h4f: isb = 8'h92;
      8'h50: isb = 8'h6c; 8'h51: isb = 8'h70; 8'h52: isb = 8'h48; 8'h53: isb = 8'h50; 8'h54: isb = 8'hfd; 8'h55: isb = 8'hed; 8'h56: isb = 8'hb9; 8'h57: isb = 8'hda;
      8'h58: isb = 8'h5e; 8'h59: isb = 8'h15; 8'h5a: isb = 8'h46; 8'h5b: isb = 8'h57; 8'h5c: isb = 8'ha7; 8'h5d: isb = 8'h8d; 8'h5e: isb = 8'h9d; 8'h5f: isb = 8'h84;
      8'h60: isb = 8'h90; 8'h61: isb = 8'hd8; 8'h62: isb = 8'hab; 8'h63: isb = 8'h00; 8'h64: isb = 8'h8c; 8'h65: isb = 8'hbc; 8'h66: isb = 8'hd3; 8'h67: isb = 8'h0a;
      8'h68: isb = 8'hf7; 8'h69: isb = 8'he4; 8'h6a: isb = 8'h58; 8'h6b: isb = 8'h05; 8'h6c: isb = 8'hb8; 8'h6d: isb = 8'hb3; 8'h6e: isb = 8'h45; 8'h6f: isb = 8'h06;
      8'h70: isb = 8'hd0; 8'h71: isb = 8'h2c; 8'h72: isb = 8'h1e; 8'h73: isb = 8'h8f; 8'h74: isb = 8'hca; 8'h75: isb = 8'h3f; 8'h76: isb = 8'h0f; 8'h77: isb = 8'h02;
      8'h78: isb = 8'hc1; 8'h79: isb = 8'haf; 8'h7a: isb = 8'hbd; 8'h7b: isb = 8'h03; 8'h7c: isb = 8'h01; 8'h7d: isb = 8'h13; 8'h7e: isb = 8'h8a; 8'h7f: isb = 8'h6b;
      8'h80: isb = 8'h3a; 8'h81: isb = 8'h91; 8'h82: isb = 8'h11; 8'h83: isb = 8'h41; 8'h84: isb = 8'h4f; 8'h85: isb = 8'h67; 8'h86: isb = 8'hdc; 8'h87: isb = 8'hea;
      8'h88: isb = 8'h97; 8'h89: isb = 8'hf2; 8'h8a: isb = 8'hcf; 8'h8b: isb = 8'hce; 8'h8c: isb = 8'hf0; 8'h8d: isb = 8'hb4; 8'h8e: isb = 8'he6; 8'h8f: isb = 8'h73;
      8'h90: isb = 8'h96; 8'h91: isb = 8'hac; 8'h92: isb = 8'h74; 8'h93: isb = 8'h22; 8'h94: isb = 8'he7; 8'h95: isb = 8'had; 8'h96: isb = 8'h35; 8'h97: isb = 8'h85;
      8'h98: isb = 8'he2; 8'h99: isb = 8'hf9; 8'h9a: isb = 8'h37; 8'h9b: isb = 8'he8; 8'h9c: isb = 8'h1c; 8'h9d: isb = 8'h75; 8'h9e: isb = 8'hdf; 8'h9f: isb = 8'h6e;
      8'ha0: isb = 8'h47; 8'ha1: isb = 8'hf1; 8'ha2: isb = 8'h1a; 8'ha3: isb = 8'h71; 8'ha4: isb = 8'h1d; 8'ha5: isb = 8'h29; 8'ha6: isb = 8'hc5; 8'ha7: isb = 8'h89;
      8'ha8: isb = 8'h6f; 8'ha9: isb = 8'hb7; 8'haa: isb = 8'h62; 8'hab: isb = 8'h0e; 8'hac: isb = 8'haa; 8'had: isb = 8'h18; 8'hae: isb = 8'hbe; 8'haf: isb = 8'h1b;
      8'hb0: isb = 8'hfc; 8'hb1: isb = 8'h56; 8'hb2: isb = 8'h3e; 8'hb3: isb = 8'h4b; 8'hb4: isb = 8'hc6; 8'hb5: isb = 8'hd2; 8'hb6: isb = 8'h79; 8'hb7: isb = 8'h20;
      8'hb8: isb = 8'h9a; 8'hb9: isb = 8'hdb; 8'hba: isb = 8'hc0; 8'hbb: isb = 8'hfe; 8'hbc: isb = 8'h78; 8'hbd: isb = 8'hcd; 8'hbe: isb = 8'h5a; 8'hbf: isb = 8'hf4;
      8'hc0: isb = 8'h1f; 8'hc1: isb = 8'hdd; 8'hc2: isb = 8'ha8; 8'hc3: isb = 8'h33; 8'hc4: isb = 8'h88; 8'hc5: isb = 8'h07; 8'hc6: isb = 8'hc7; 8'hc7: isb = 8'h31;
      8'hc8: isb = 8'hb1; 8'hc9: isb = 8'h12; 8'hca: isb = 8'h10; 8'hcb: isb = 8'h59; 8'hcc: isb = 8'h27; 8'hcd: isb = 8'h80; 8'hce: isb = 8'hec; 8'hcf: isb = 8'h5f;
      8'hd0: isb = 8'h60; 8'hd1: isb = 8'h51; 8'hd2: isb = 8'h7f; 8'hd3: isb = 8'ha9; 8'hd4: isb = 8'h19; 8'hd5: isb = 8'hb5; 8'hd6: isb = 8'h4a; 8'hd7: isb = 8'h0d;
      8'hd8: isb = 8'h2d; 8'hd9: isb = 8'he5; 8'hda: isb = 8'h7a; 8'hdb: isb = 8'h9f; 8'hdc: isb = 8'h93; 8'hdd: isb = 8'hc9; 8'hde: isb = 8'h9c; 8'hdf: isb = 8'hef;
      8'he0: isb = 8'ha0; 8'he1: isb = 8'he0; 8'he2: isb = 8'h3b; 8'he3: isb = 8'h4d; 8'he4: isb = 8'hae; 8'he5: isb = 8'h2a; 8'he6: isb = 8'hf5; 8'he7: isb = 8'hb0;
      8'he8: isb = 8'hc8; 8'he9: isb = 8'heb; 8'hea: isb = 8'hbb; 8'heb: isb = 8'h3c; 8'hec: isb = 8'h83; 8'hed: isb = 8'h53; 8'hee: isb = 8'h99; 8'hef: isb = 8'h61;
      8'hf0: isb = 8'h17; 8'hf1: isb = 8'h2b; 8'hf2: isb = 8'h04; 8'hf3: isb = 8'h7e; 8'hf4: isb = 8'hba; 8'hf5: isb = 8'h77; 8'hf6: isb = 8'hd6; 8'hf7: isb = 8'h26;
      8'hf8: isb = 8'he1; 8'hf9: isb = 8'h69; 8'hfa: isb = 8'h14; 8'hfb: isb = 8'h63; 8'hfc: isb = 8'h55; 8'hfd: isb = 8'h21; 8'hfe: isb = 8'h0c; 8'hff: isb = 8'h7d;
      default: isb = 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // constant multiplier k built from the a*2, a*4, a*8 xtime chain
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction
  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction
  // row r of column c takes the byte from column c-r: right rotation of each row
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int S = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
    assign sb[8*i +: 8] = isb(st_q[8*S +: 8]);
  end
  assign ak = sb ^ round_key;
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mc[32*c +: 32] = imc(ak[32*c +: 32]);
  end
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    dec_d = dec_q;
    rn_d = rn_q;
    vf_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        st_d = cipher_text ^ round_key;
        rn_d = LAST - 4'd1;
        state_d = RUN;
      end
    end else if (rn_q == 4'd0) begin
      dec_d = ak;
      vf_d = 1'b1;
      rn_d = LAST;
      state_d = IDLE;
    end else begin
      st_d = mc;
      rn_d = rn_q - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      st_q <= '0;
      dec_q <= '0;
      rn_q <= LAST;
      vf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
      dec_q <= dec_d;
      rn_q <= rn_d;
      vf_q <= vf_d;
    end
  end
  assign dec_data = dec_q;
  assign round_num = rn_q;
  assign valid_flag = vf_q;
`ifdef AES_DEC_BUSY_EN
  assign busy = state_q == RUN;
`endif
endmodule

// File: tb/tb_inv_rounds.sv
// tb_inv_rounds: scoreboard bench for inv_rounds; expected plaintexts come from a forward AES model in the bench
module tb_inv_rounds;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [0:127] cipher_text = '0, round_key, dec_data;
  logic [3:0] round_num;
  logic valid_flag;
`ifdef AES_DEC_BUSY_EN
  logic busy;
`endif
  typedef struct {logic [127:0] pt; int e;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [127:0] keys [16];
  logic [127:0] rk_m [11];
  logic [7:0] sbox [256];
  logic [127:0] last = '0;
  int edge_n = 0, n_vec = 0, n_err = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CZ = 128'hc7d12419489e3b6233a2c5a7f4563172;
  localparam logic [127:0] PZ = 128'h00000101030307070f0f1f1f3f3f7f7f;

  inv_rounds dut (
`ifdef AES_DEC_BUSY_EN
    .busy(busy),
`endif
    .clk(clk), .reset(reset), .start(start), .cipher_text(cipher_text),
    .round_key(round_key), .dec_data(dec_data), .round_num(round_num), .valid_flag(valid_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  assign round_key = keys[round_num];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // forward S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_def(input int x);
    logic [7:0] b = '0;
    for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [7:0] bt(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s, t;
    s = pt ^ rk_m[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[bt(s, i)];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[127-8*(4*c+q) -: 8] = bt(t, 4*((c+q)%4) + q);
      if (r < 10) begin
        t = s;
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++)
            s[127-8*(4*c+q) -: 8] = gmul(bt(t, 4*c+q), 8'h02) ^ gmul(bt(t, 4*c+(q+1)%4), 8'h03)
                                    ^ bt(t, 4*c+(q+2)%4) ^ bt(t, 4*c+(q+3)%4);
      end
      s ^= rk_m[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic reset_vals(input string nm);
    check({nm, "_dec"}, dec_data, 128'h0);
    check({nm, "_rn"}, 128'(round_num), 128'(10));
    check({nm, "_vf"}, 128'(valid_flag), 128'(0));
`ifdef AES_DEC_BUSY_EN
    check({nm, "_busy"}, 128'(busy), 128'(0));
`endif
  endtask

  // one block: start edge E0 follows the call; seq adds round_num checks and a second start at E4
  task automatic blk(input logic [127:0] key, ct, pt, input bit hold, seq, rel);
    expand(key);
    for (int i = 0; i < 11; i++) keys[i] = rk_m[i];
    cipher_text = ct;
    start = 1'b1;
    if (rel) reset = 1'b0;
    if (seq) check("rn_idle", 128'(round_num), 128'(10));
    @(posedge clk); #1;
    sb_q.push_back('{pt, edge_n + 10});
    start = hold;
    cipher_text = rnd128();
    if (seq) check("rn_e0", 128'(round_num), 128'(9));
`ifdef AES_DEC_BUSY_EN
    if (seq) check("busy_e0", 128'(busy), 128'(1));
`endif
    for (int k = 1; k <= 10; k++) begin
      if (seq && k == 4) start = 1'b1;
      @(posedge clk); #1;
      if (seq && k == 4) start = hold;
      if (seq) check("rn_seq", 128'(round_num), 128'(k == 10 ? 10 : 9 - k));
`ifdef AES_DEC_BUSY_EN
      if (seq) check("busy_seq", 128'(busy), 128'(k < 10));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (reset) last = '0;
    else if (valid_flag) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_valid: got pulse with dec_data %h, expected no pulse", dec_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("dec_data", dec_data, mon_e.pt);
        check("valid_edge", 128'(edge_n), 128'(mon_e.e));
        last = mon_e.pt;
      end
    end else check("dec_hold", dec_data, last);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p;
    bit h;
    for (int i = 0; i < 16; i++) keys[i] = '0;
    for (int x = 0; x < 256; x++) sbox[x] = sbox_def(x);
    repeat (3) @(posedge clk);
    #1 reset_vals("reset");
    @(posedge clk); #1 reset = 1'b0;
    blk(K1, C1, P1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 blk('0, CZ, PZ, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 blk(K1, C1, P1, 1'b1, 1'b0, 1'b0);
    blk('0, CZ, PZ, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 expand(K1);
    for (int i = 0; i < 11; i++) keys[i] = rk_m[i];
    cipher_text = C1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1 reset_vals("async_rst");
    @(posedge clk); #1 reset_vals("rst_held");
    blk(K1, C1, P1, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      k = rnd128();
      p = rnd128();
      expand(k);
      h = 1'($urandom_range(0, 1));
      blk(k, enc(p), p, h, 1'b0, 1'b0);
      if (!h) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (!h) #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("drain", 128'(sb_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inv_rounds.md
# inv_rounds

Iterative AES-128 inverse-cipher datapath: the decryption counterpart of the encryption `Rounds` block. It takes a 128-bit ciphertext and a stream of round keys, supplied one per clock in reverse schedule order (key 10 down to key 0). It produces the plaintext after 11 clock edges. It sits between the key-schedule/key-store logic, which indexes keys by `round_num`, and the decryption output register stage.

## Interface
- `NR`, default 10: number of rounds. Only 10 (AES-128) is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a decryption. Sampled only in IDLE.
- `cipher_text`  in  [0:127]  ciphertext. Byte i is bits [8i:8i+7]; the state is column-major (bytes 0..3 form column 0). Sampled on the start edge only.
- `round_key`  in  [0:127]  round key whose index equals the current `round_num`. Same byte ordering as `cipher_text`.
- `dec_data`  out  [0:127]  decrypted plaintext. Holds its value until the next completion.
- `round_num`  out  [3:0]  index of the key that must be on `round_key` during the current cycle.
- `valid_flag`  out  1  one-cycle pulse: `dec_data` has just been updated.

## Operation
- State register `st[0:127]` plus an FSM with states IDLE and RUN.
- **IDLE**: `round_num` = 10.
  - On an edge with `start`=1: `st` <= `cipher_text` ^ `round_key` (key 10), `round_num` <= 9, go to RUN.
- **RUN, `round_num` 9..1**: `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ `round_key`), then `round_num` decrements.
- **RUN, `round_num` = 0**: `dec_data` <= InvSubBytes(InvShiftRows(`st`)) ^ `round_key`, `valid_flag` <= 1, `round_num` <= 10, go to IDLE.
- Transform definitions:
  - InvShiftRows: row r is rotated right by r bytes.
  - InvSubBytes: inverse S-box, implemented as a combinational 256-entry case per byte (16 instances).
  - InvMixColumns: per column, matrix {0e,0b,0d,09} in GF(2^8) with reduction polynomial 0x11b, built from xtime chains only (no multipliers).
- `start` asserted while in RUN is ignored; it is not queued.
- `start` held high continuously: a new operation begins on the edge immediately after the return to IDLE.
- `cipher_text` may change after the start edge without affecting the result.

## Timing
- Reset values: `dec_data`=0, `round_num`=10, `valid_flag`=0, FSM=IDLE, `st`=0.
- Latency: start sampled at edge E0. Keys 9..1 are consumed at E1..E9 and key 0 at E10. `valid_flag` is high from E10 to E11.
- Throughput: one block per 11 cycles with `start` held high.
- `round_key` must be stable around each edge at the key index that `round_num` showed during the preceding cycle. Key lookup is combinational from `round_num`, with zero latency.
- Reset asserted mid-operation: immediate return to the reset values. The partial result is discarded and no `valid_flag` is produced.
- Reset deasserted together with `start`=1: the first edge after deassertion counts as E0.
- Critical path: InvShiftRows → InvSubBytes → XOR → InvMixColumns in one cycle. No pipelining.

## Configuration
- Macro `AES_DEC_BUSY_EN`.
  - Defined: adds output `busy` (1 bit). `busy` is 1 in RUN, 0 in IDLE, and 0 in reset. It rises at E0 and falls at E10.
  - Undefined: no `busy` port; behaviour is otherwise identical.

## Test plan
- **FIPS-197 C.1 vector**: keys from 000102030405060708090a0b0c0d0e0f (key 10 = 13111d7fe3944a17f307a78b4d2b30c5, supplied by `round_num`), `cipher_text`=69c4e0d86a7b0430d8cdb78070b4c55a, `start` pulsed → `valid_flag` pulses at E10 and `dec_data`=00112233445566778899aabbccddeeff.
- **Round-trip with the encryption block**: all-zero cipher key (key 10 = b4ef5bcb3e92e21123e951cf6f8f188e … key 0 = 0), `cipher_text`=c7d12419489e3b6233a2c5a7f4563172 → `dec_data`=00000101030307070f0f1f1f3f3f7f7f at E10.
- **Mid-run start and key indexing**: `round_num` sequence observed as 10,9,…,0,10. A second `start` pulse at E4 is ignored: exactly one `valid_flag` pulse, and the result is unchanged.
- **Back-to-back**: `start` held high for two blocks (the C.1 vector, then the all-zero-key vector) → `valid_flag` at E10 and E21, both results correct, and `dec_data` holds its value between the pulses.
- **Reset mid-operation**: `reset` asserted asynchronously between edges E5 and E6 → outputs immediately 0/10/0 with no `valid_flag`. A restart after release yields the correct C.1 plaintext.
- **`AES_DEC_BUSY_EN` defined**: `busy` is high from E0 to E10 on the C.1 run, and 0 during and after reset.
